// File: rtl/cpu_pkg.sv
// Shared constants and types for the RV32I control path.
// Also used by the later pipelined core, so keep the encodings stable.
package cpu_pkg;

  localparam int CPU_WORD = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_ADD  = 3'b000;

  localparam logic [31:0] ECALL = 32'h0000_0073;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT,
    S_TRAP
  } ctrl_state_t;

  typedef enum logic [1:0] {
    TC_NONE        = 2'd0,
    TC_ILLEGAL     = 2'd1,
    TC_MEM_TIMEOUT = 2'd2
  } trap_cause_t;

  typedef enum logic [1:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_ECALL
  } instr_class_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: ir -> {class, illegal}.
// Load/store widths follow the RV32I func3 encodings; everything else is illegal.
module ctrl_decode
  import cpu_pkg::*;
(
  input  logic [31:0]  i_ir,
  output instr_class_t o_cls,
  output logic         o_illegal
);

  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic [6:0] w_f7;

  assign w_opc = i_ir[6:0];
  assign w_f3  = i_ir[14:12];
  assign w_f7  = i_ir[31:25];

  always_comb begin
    o_cls     = CLS_ALU;
    o_illegal = 1'b1;
    case (w_opc)
      OPC_LOAD: begin
        o_cls     = CLS_LOAD;
        o_illegal = !(w_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      end
      OPC_STORE: begin
        o_cls     = CLS_STORE;
        o_illegal = !(w_f3 inside {3'b000, 3'b001, 3'b010});
      end
      OPC_LUI:    o_illegal = 1'b0;
      OPC_OP_IMM: o_illegal = (w_f3 != F3_ADDI);
      OPC_OP:     o_illegal = (w_f3 != F3_ADD) || (w_f7 != 7'd0);
      OPC_SYSTEM: begin
        o_cls     = CLS_ECALL;
        o_illegal = (i_ir[31:7] != ECALL[31:7]);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core.
// Traps on illegal encodings and data-memory timeout, halts on ECALL, counts retires.
module multicycle_controller
  import cpu_pkg::*;
#(
  parameter int WORD        = CPU_WORD,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [WORD-1:0]  instr,
  output logic             mem_req,
  input  logic             mem_ready,
  output logic             memWrite,
  output logic             regWrite,
  output logic             pcWrite,
  output logic [WORD-1:0]  ir,
  output logic             halt,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

  ctrl_state_t  r_state, w_state_next;
  trap_cause_t  r_cause, w_cause_next;
  logic [WORD-1:0]   r_ir;
  logic [WAIT_W-1:0] r_wait, w_wait_next;
  logic [CNT_W-1:0]  r_retired;
  instr_class_t w_cls;
  logic         w_illegal;
  logic         w_mem_timeout;
  logic         w_is_mem;

  ctrl_decode u_decode (
    .i_ir      (r_ir[31:0]),
    .o_cls     (w_cls),
    .o_illegal (w_illegal)
  );

  assign w_is_mem      = (w_cls == CLS_LOAD) || (w_cls == CLS_STORE);
  // With MEM_TIMEOUT == 0 the counter still runs but can never fire.
  assign w_mem_timeout = (MEM_TIMEOUT != 0) && (r_wait == WAIT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    w_state_next = r_state;
    w_cause_next = r_cause;
    w_wait_next  = r_wait;
    instr_ready  = 1'b0;
    mem_req      = 1'b0;
    memWrite     = 1'b0;
    regWrite     = 1'b0;
    pcWrite      = 1'b0;
    case (r_state)
      S_FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) w_state_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_illegal) begin
          w_state_next = S_TRAP;
          w_cause_next = TC_ILLEGAL;
        end else if (w_cls == CLS_ECALL) begin
          w_state_next = S_HALT;
        end else begin
          w_state_next = S_EXEC;
        end
      end
      S_EXEC: w_state_next = w_is_mem ? S_MEM : S_WB;
      S_MEM: begin
        mem_req  = 1'b1;
        memWrite = (w_cls == CLS_STORE);
        // A completion in the final wait cycle beats the timeout.
        if (mem_ready) begin
          w_wait_next = '0;
          if (w_cls == CLS_STORE) begin
            pcWrite      = 1'b1;
            w_state_next = S_FETCH;
          end else begin
            w_state_next = S_WB;
          end
        end else if (w_mem_timeout) begin
          w_wait_next  = '0;
          w_state_next = S_TRAP;
          w_cause_next = TC_MEM_TIMEOUT;
        end else begin
          w_wait_next = r_wait + 1'b1;
        end
      end
      S_WB: begin
        regWrite     = 1'b1;
        pcWrite      = 1'b1;
        w_state_next = S_FETCH;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_cause   <= TC_NONE;
      r_ir      <= '0;
      r_wait    <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_state_next;
      r_cause <= w_cause_next;
      r_wait  <= w_wait_next;
      if (r_state == S_FETCH && instr_valid) r_ir <= instr;
      if (pcWrite) r_retired <= r_retired + 1'b1;
    end
  end

  assign ir         = r_ir;
  assign halt       = (r_state == S_HALT);
  assign trap       = (r_state == S_TRAP);
  assign trap_cause = r_cause;
  assign retired    = r_retired;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: stimulus queues the expected retire/trap/halt events,
// a monitor pops and checks them as the controller produces them.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = 32'd0;
  logic        mem_req;
  logic        mem_ready = 1'b0;
  logic        memWrite;
  logic        regWrite;
  logic        pcWrite;
  logic [31:0] ir;
  logic        halt;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] retired;

  multicycle_controller #(
    .WORD        (32),
    .MEM_TIMEOUT (4),
    .CNT_W       (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .mem_req     (mem_req),
    .mem_ready   (mem_ready),
    .memWrite    (memWrite),
    .regWrite    (regWrite),
    .pcWrite     (pcWrite),
    .ir          (ir),
    .halt        (halt),
    .trap        (trap),
    .trap_cause  (trap_cause),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 retire (pcWrite pulse), 1 trap, 2 halt
  typedef struct {
    int kind;
    int lat;
    int regw;
    int memw;
    int memcyc;
    int ret;
    int cause;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails = 0;
  int   mem_wait = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input int lat, input int regw, input int memw,
                      input int memcyc, input int ret, input int cause);
    exp_t e;
    e.kind = kind; e.lat = lat; e.regw = regw; e.memw = memw;
    e.memcyc = memcyc; e.ret = ret; e.cause = cause;
    sb.push_back(e);
  endtask

  // Data-memory model: mem_ready rises on the (mem_wait+1)-th MEM cycle.
  initial begin
    int mem_cnt = 0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        mem_ready = (mem_cnt == mem_wait);
        mem_cnt++;
      end else begin
        mem_ready = 1'b0;
        mem_cnt = 0;
      end
    end
  end

  // Monitor: latency counted from the FETCH cycle in which the handshake occurs.
  initial begin
    int   acc = 0;
    int   memcyc = 0;
    int   memw = 0;
    logic prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        prev = 1'b0; memcyc = 0; memw = 0;
        continue;
      end
      if (instr_ready && instr_valid) begin
        acc = cyc; memcyc = 0; memw = 0;
      end
      if (mem_req) memcyc++;
      if (memWrite) memw = 1;
      if (pcWrite) begin
        if (sb.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_retire: got pcWrite expected no event");
        end else begin
          e = sb.pop_front();
          $display("txn retire ir=%08h lat=%0d memcyc=%0d retired=%0d", ir, cyc - acc, memcyc, retired);
          check("event_kind", 0, e.kind);
          check("retire_latency", cyc - acc, e.lat);
          check("retire_regWrite", {31'd0, regWrite}, e.regw);
          check("retire_memWrite_seen", memw, e.memw);
          check("retire_mem_cycles", memcyc, e.memcyc);
          check("retired_before", retired, e.ret);
        end
      end
      if ((halt || trap) && !prev) begin
        if (sb.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_stop: got halt=%0d trap=%0d expected no event", halt, trap);
        end else begin
          e = sb.pop_front();
          $display("txn stop ir=%08h halt=%0d trap=%0d cause=%0d lat=%0d", ir, halt, trap, trap_cause, cyc - acc);
          check("event_kind", trap ? 1 : 2, e.kind);
          check("stop_latency", cyc - acc, e.lat);
          check("stop_mem_cycles", memcyc, e.memcyc);
          check("stop_trap_cause", {30'd0, trap_cause}, e.cause);
          check("stop_retired", retired, e.ret);
          check("stop_instr_ready", {31'd0, instr_ready}, 0);
        end
      end
      prev = halt || trap;
    end
  end

  task automatic issue(input logic [31:0] w, input int mw);
    int n;
    mem_wait = mw;
    @(negedge clk);
    instr = w;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    instr = 32'd0;
    n = 0;
    while (!(instr_ready || halt || trap) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++; fails++;
      $display("FAIL issue_timeout: instr %08h got no completion, required one within 40 cycles", w);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_instr_ready", {31'd0, instr_ready}, 1);
    check("rst_mem_req", {31'd0, mem_req}, 0);
    check("rst_memWrite", {31'd0, memWrite}, 0);
    check("rst_regWrite", {31'd0, regWrite}, 0);
    check("rst_pcWrite", {31'd0, pcWrite}, 0);
    check("rst_ir", ir, 0);
    check("rst_halt", {31'd0, halt}, 0);
    check("rst_trap", {31'd0, trap}, 0);
    check("rst_trap_cause", {30'd0, trap_cause}, 0);
    check("rst_retired", retired, 0);
    rst_n = 1'b1;

    // ADDI, LW with two wait cycles, SW with immediate ready
    push(0, 3, 1, 0, 0, 0, 0);
    issue(32'h00500093, 0);
    check("addi_retired", retired, 1);
    check("addi_ir", ir, 32'h00500093);
    push(0, 6, 1, 0, 3, 1, 0);
    issue(32'h0000A103, 2);
    push(0, 3, 0, 1, 1, 2, 0);
    issue(32'h0020A223, 0);
    check("sw_retired", retired, 3);

    // Illegal encodings
    push(1, 2, 0, 0, 0, 3, 1);
    issue(32'hFFFFFFFF, 0);
    repeat (3) @(negedge clk);
    check("trap_sticky", {31'd0, trap}, 1);
    check("trap_retired_unchanged", retired, 3);
    do_reset();
    push(1, 2, 0, 0, 0, 0, 1);
    issue(32'h00109093, 0);
    do_reset();
    push(1, 2, 0, 0, 0, 0, 1);
    issue(32'h402081B3, 0);

    // MEM timeout at 4 cycles; ready on the 4th cycle wins
    do_reset();
    push(1, 7, 0, 0, 4, 0, 2);
    issue(32'h0000A103, 1000);
    check("timeout_cause", {30'd0, trap_cause}, 2);
    do_reset();
    push(0, 7, 1, 0, 4, 0, 0);
    issue(32'h0000A103, 3);
    check("late_ready_trap", {31'd0, trap}, 0);
    check("late_ready_retired", retired, 1);

    // ADD then ECALL
    do_reset();
    push(0, 3, 1, 0, 0, 0, 0);
    issue(32'h002081B3, 0);
    push(2, 2, 0, 0, 0, 1, 0);
    issue(32'h00000073, 0);
    instr = 32'h00500093;
    instr_valid = 1'b1;
    repeat (4) @(negedge clk);
    instr_valid = 1'b0;
    #1;
    check("halt_sticky", {31'd0, halt}, 1);
    check("halt_instr_ready", {31'd0, instr_ready}, 0);
    check("halt_retired", retired, 1);

    // Asynchronous reset in the middle of a load
    do_reset();
    push(0, 3, 1, 0, 0, 0, 0);
    issue(32'h00500093, 0);
    mem_wait = 1000;
    @(negedge clk);
    instr = 32'h0000A103;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("midlw_in_mem", {31'd0, mem_req}, 1);
    #1 rst_n = 1'b0;
    #1;
    check("midlw_rst_mem_req", {31'd0, mem_req}, 0);
    check("midlw_rst_ir", ir, 0);
    check("midlw_rst_retired", retired, 0);
    check("midlw_rst_trap", {31'd0, trap}, 0);
    check("midlw_rst_halt", {31'd0, halt}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    push(0, 3, 1, 0, 0, 0, 0);
    issue(32'h00500093, 0);
    check("post_rst_retired", retired, 1);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
